// File: rtl/dmem_bridge_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dmem_bridge_pkg                                               |
// | Purpose  : Shared types and constants for the data-memory bridge.        |
// |            Holds the bridge state encoding, the default error read data  |
// |            and a small address-alignment helper.                         |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package dmem_bridge_pkg;

    // Bridge transaction states
    typedef enum logic [1:0] {
        DMB_IDLE = 2'd0,
        DMB_REQ  = 2'd1,
        DMB_DONE = 2'd2
    } dmb_state_e;

    // Read data handed back on an aborted or misaligned load
    localparam logic [31:0] DMB_ERR_DATA = 32'hFFFF_FFFF;

    // A word access is misaligned when either low byte-address bit is set
    function automatic logic dmb_misaligned(input logic [1:0] addr_lo);
        return (addr_lo != 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dmem_bridge                                                   |
// | Purpose  : Turns each datapath load/store into one single-beat           |
// |            cyc/stb/we/ack bus transaction, stalling the datapath while   |
// |            the transaction is outstanding. Misaligned accesses and bus   |
// |            timeouts are reported through sticky error flags.             |
// | Ports    : clk, cpu_rst_n (async, active low)                            |
// |            mem_ren/mem_wen/mem_addr/mem_dout -> mem_din, stall  (CPU)    |
// |            bus_cyc/stb/we/addr/wdata, bus_rdata/bus_ack          (bus)   |
// |            err_misalign, err_timeout, err_clr                  (status)  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned TO_WIDTH = 8,
    parameter logic [31:0] ERR_DATA = DMB_ERR_DATA
) (
    input  logic        clk,
    input  logic        cpu_rst_n,
    // datapath side
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        stall,
    // bus side
    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    // status
    output logic        err_misalign,
    output logic        err_timeout,
    input  logic        err_clr
);

    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);
    localparam logic [TO_WIDTH-1:0] TO_MAX  = '1;

    dmb_state_e          state_q;
    logic                cyc_q;
    logic                stb_q;
    logic                we_q;
    logic [31:0]         addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         data_q;
    logic [TO_WIDTH-1:0] cnt_q;
    logic                err_mis_q;
    logic                err_to_q;

    logic                w_req;

    assign w_req = mem_ren | mem_wen;

    // The reset term makes stall drop immediately on an asynchronous reset
    // even while the datapath keeps its request asserted.
    assign stall = cpu_rst_n &
                   (((state_q == DMB_IDLE) & w_req) | (state_q == DMB_REQ));

    assign bus_cyc      = cyc_q;
    assign bus_stb      = stb_q;
    assign bus_we       = we_q;
    assign bus_addr     = addr_q;
    assign bus_wdata    = wdata_q;
    assign mem_din      = data_q;
    assign err_misalign = err_mis_q;
    assign err_timeout  = err_to_q;

    always_ff @(posedge clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q   <= DMB_IDLE;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            data_q    <= 32'd0;
            cnt_q     <= '0;
            err_mis_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            // Clear first so that a flag set later in this block overrides it
            if (err_clr) begin
                err_mis_q <= 1'b0;
                err_to_q  <= 1'b0;
            end

            case (state_q)
                DMB_IDLE: begin
                    if (w_req) begin
                        if (dmb_misaligned(mem_addr[1:0])) begin
                            err_mis_q <= 1'b1;
                            data_q    <= ERR_DATA;
                            state_q   <= DMB_DONE;
                        end else begin
                            addr_q  <= {mem_addr[31:2], 2'b00};
                            wdata_q <= mem_dout;
                            we_q    <= mem_wen;   // store wins when both set
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= DMB_REQ;
                        end
                    end
                end

                DMB_REQ: begin
                    if (cnt_q != TO_MAX) begin
                        cnt_q <= cnt_q + TO_WIDTH'(1);
                    end
                    // Ack is checked first so it wins over a same-cycle timeout
                    if (bus_ack) begin
                        data_q  <= we_q ? 32'd0 : bus_rdata;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= DMB_DONE;
                    end else if (cnt_q == TO_LAST) begin
                        cyc_q    <= 1'b0;
                        stb_q    <= 1'b0;
                        we_q     <= 1'b0;
                        err_to_q <= 1'b1;
                        data_q   <= ERR_DATA;
                        state_q  <= DMB_DONE;
                    end
                end

                // Datapath commits here; a still-held request belongs to the
                // next instruction and is picked up in the following IDLE.
                DMB_DONE: begin
                    state_q <= DMB_IDLE;
                end

                default: begin
                    cyc_q   <= 1'b0;
                    stb_q   <= 1'b0;
                    we_q    <= 1'b0;
                    state_q <= DMB_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
